// File: rtl/game_pkg.sv
// Shared types and constants for the memorization-game round controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW,
        ST_ENTRY,
        ST_RESULT,
        ST_OVER
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_PASS = 2'b01,
        RES_FAIL = 2'b10
    } result_t;

    localparam int unsigned         DIGIT_W     = 4;
    localparam logic [DIGIT_W-1:0]  BLANK_DIGIT = 4'hF;

    // Galois right-shift feedback mask for taps 16,14,13,11
    localparam logic [15:0]         LFSR_TAPS   = 16'hB400;

    // Fold each raw nibble into the 0..9 range (10..15 -> 0..5)
    function automatic logic [15:0] map_digits(input logic [15:0] raw);
        logic [DIGIT_W-1:0] nib;
        logic [15:0]        mapped;
        mapped = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            nib = raw[i*DIGIT_W +: DIGIT_W];
            mapped[i*DIGIT_W +: DIGIT_W] = (nib >= 4'd10) ? (nib - 4'd10) : nib;
        end
        return mapped;
    endfunction

    // True when any digit of the entry is still unfilled
    function automatic logic has_blank(input logic [15:0] value);
        logic found;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (value[i*DIGIT_W +: DIGIT_W] == BLANK_DIGIT) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used as the target digit source.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        masterClk,
    input  logic        rst,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift right, folding the feedback bit into the tap positions
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end

    // LFSR register; restarts from the seed on reset
    always_ff @(posedge masterClk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/round_checker.sv
// Per-round controller: shows a random BCD target, clears the keypad
// decoder, compares the entered digits and keeps score and lives.
module round_checker
    import game_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES   = 200_000_000,
    parameter int unsigned RESULT_CYCLES = 100_000_000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int unsigned MAX_LIVES     = 3
) (
    input  logic        masterClk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] entry,
    input  logic        entryReady,
    output logic        entryClear,
    output logic [15:0] target,
    output logic        showTarget,
    output logic [1:0]  result,
    output logic [7:0]  score,
    output logic [1:0]  lives,
    output logic        gameOver
);

    localparam logic [1:0]  LIVES_INIT = 2'(MAX_LIVES);
    localparam logic [31:0] SHOW_LAST  = 32'(SHOW_CYCLES - 1);
    localparam logic [31:0] RES_LAST   = 32'(RESULT_CYCLES - 1);

    logic [15:0] lfsr_value;

    state_t      state_q,       state_d;
    logic [31:0] cnt_q,         cnt_d;
    logic [15:0] target_q,      target_d;
    logic        entry_clear_q, entry_clear_d;
    result_t     result_q,      result_d;
    logic [7:0]  score_q,       score_d;
    logic [1:0]  lives_q,       lives_d;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .masterClk (masterClk),
        .rst       (rst),
        .value     (lfsr_value)
    );

    // Next-state, counters, target latch and comparator
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        target_d      = target_q;
        entry_clear_d = 1'b0;
        result_d      = result_q;
        score_d       = score_q;
        lives_d       = lives_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    target_d = map_digits(lfsr_value);
                    cnt_d    = '0;
                    score_d  = '0;
                    lives_d  = LIVES_INIT;
                    state_d  = ST_SHOW;
                end
            end

            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d         = '0;
                    entry_clear_d = 1'b1;
                    state_d       = ST_ENTRY;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            ST_ENTRY: begin
                // The clear cycle is skipped so a stale decoder flag is never taken
                if (!entry_clear_q && entryReady) begin
                    cnt_d   = '0;
                    state_d = ST_RESULT;
                    if ((entry == target_q) && !has_blank(entry)) begin
                        result_d = RES_PASS;
                        score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    end else begin
                        result_d = RES_FAIL;
                        lives_d  = (lives_q != 2'd0) ? lives_q - 2'd1 : lives_q;
                    end
                end
            end

            ST_RESULT: begin
                if (cnt_q == RES_LAST) begin
                    cnt_d    = '0;
                    result_d = RES_NONE;
                    if (lives_q == 2'd0) begin
                        state_d = ST_OVER;
                    end else begin
                        target_d = map_digits(lfsr_value);
                        state_d  = ST_SHOW;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            ST_OVER: begin
                if (start) begin
                    target_d = map_digits(lfsr_value);
                    cnt_d    = '0;
                    score_d  = '0;
                    lives_d  = LIVES_INIT;
                    state_d  = ST_SHOW;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge masterClk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            target_q      <= '0;
            entry_clear_q <= 1'b0;
            result_q      <= RES_NONE;
            score_q       <= '0;
            lives_q       <= LIVES_INIT;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            target_q      <= target_d;
            entry_clear_q <= entry_clear_d;
            result_q      <= result_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
        end
    end

    assign entryClear = entry_clear_q;
    assign target     = target_q;
    assign showTarget = (state_q == ST_SHOW);
    assign result     = result_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign gameOver   = (state_q == ST_OVER);

endmodule

// File: tb/tb_round_checker.sv
// Randomized round-level bench for round_checker with a behavioural game model.
module tb_round_checker;

    localparam int unsigned SHOW  = 4;
    localparam int unsigned RES   = 3;
    localparam int unsigned MAXL  = 3;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        masterClk = 1'b0;
    logic        rst       = 1'b0;
    logic        start     = 1'b0;
    logic [15:0] entry     = '0;
    logic        entryReady = 1'b0;
    logic        entryClear;
    logic [15:0] target;
    logic        showTarget;
    logic [1:0]  result;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic        gameOver;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int          exp_score;
    int          exp_lives;
    logic [15:0] exp_t;

    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    round_checker #(
        .SHOW_CYCLES   (SHOW),
        .RESULT_CYCLES (RES),
        .LFSR_SEED     (SEED),
        .MAX_LIVES     (MAXL)
    ) dut (
        .masterClk  (masterClk),
        .rst        (rst),
        .start      (start),
        .entry      (entry),
        .entryReady (entryReady),
        .entryClear (entryClear),
        .target     (target),
        .showTarget (showTarget),
        .result     (result),
        .score      (score),
        .lives      (lives),
        .gameOver   (gameOver)
    );

    always #5 masterClk = ~masterClk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Feedback mask built from the tap list rather than a literal
    function automatic logic [15:0] tap_mask();
        int taps[4] = '{16, 14, 13, 11};
        logic [15:0] m = '0;
        foreach (taps[k]) m[taps[k]-1] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic lsb = x[0];
        x = x >> 1;
        if (lsb) x = x ^ tap_mask();
        return x;
    endfunction

    function automatic logic [15:0] digits_of(input logic [15:0] raw);
        logic [15:0] o = '0;
        for (int i = 0; i < 4; i++) begin
            int n = int'(raw[i*4 +: 4]);
            o[i*4 +: 4] = 4'(n % 10);
        end
        return o;
    endfunction

    function automatic logic all_bcd(input logic [15:0] v);
        for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Reference LFSR: m_prev is the value the DUT saw at the latest edge
    always @(posedge masterClk or posedge rst) begin
        if (rst) begin
            m_lfsr = SEED;
            m_prev = SEED;
        end else begin
            m_prev = m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    task automatic tick();
        @(posedge masterClk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_show"},  showTarget, 0);
        check_eq({tag, "_res"},   result,     0);
        check_eq({tag, "_score"}, score,      0);
        check_eq({tag, "_lives"}, lives,      MAXL);
        check_eq({tag, "_over"},  gameOver,   0);
        check_eq({tag, "_clr"},   entryClear, 0);
    endtask

    // Plays one round starting from the first SHOW cycle sample
    task automatic play_round(input bit is_pass, input bit stale, input int unsigned wait_cycles,
                              input bit blank, input bit reset_mid);
        logic [15:0] val;
        int unsigned pos;
        logic [1:0]  code;
        exp_t = digits_of(m_prev);
        check_eq("target_latch", target, exp_t);
        check_eq("target_bcd", all_bcd(target), 1);
        if (stale) begin
            entry      = exp_t ^ 16'h1111;
            entryReady = 1'b1;
        end
        for (int i = 0; i < int'(SHOW); i++) begin
            check_eq("show_high", showTarget, 1);
            check_eq("show_noclr", entryClear, 0);
            check_eq("show_nores", result, 0);
            start = 1'($urandom % 2);
            tick();
        end
        start = 1'b0;
        check_eq("clr_show", showTarget, 0);
        check_eq("clr_pulse", entryClear, 1);
        check_eq("clr_nores", result, 0);
        check_eq("clr_target", target, exp_t);
        tick();
        check_eq("entry_clr", entryClear, 0);
        check_eq("entry_nores", result, 0);
        check_eq("entry_show", showTarget, 0);

        if (is_pass) begin
            val = exp_t;
        end else if (blank) begin
            val = exp_t;
            pos = $urandom % 4;
            val[pos*4 +: 4] = 4'hF;
        end else begin
            val = (exp_t != 16'h1234) ? 16'h1234 : 16'h5678;
        end
        entry = val;
        if (wait_cycles > 0) begin
            entryReady = 1'b0;
            for (int unsigned w = 0; w < wait_cycles; w++) begin
                tick();
                check_eq("wait_nores", result, 0);
            end
        end
        entryReady = 1'b1;
        tick();
        entryReady = 1'b0;
        if (is_pass) begin
            code = 2'b01;
            exp_score = (exp_score < 255) ? exp_score + 1 : 255;
        end else begin
            code = 2'b10;
            exp_lives = exp_lives - 1;
        end
        check_eq("cmp_result", result, code);
        check_eq("cmp_score", score, exp_score);
        check_eq("cmp_lives", lives, exp_lives);

        if (reset_mid) begin
            tick();
            rst = 1'b1;
            #1;
            check_reset_outs("rst_mid");
            check_eq("rst_mid_target", target, 0);
            exp_score = 0;
            exp_lives = MAXL;
            return;
        end

        for (int unsigned r = 1; r < RES; r++) begin
            tick();
            check_eq("res_hold", result, code);
        end
        tick();
        check_eq("res_end", result, 0);
        check_eq("res_score", score, exp_score);
        check_eq("res_lives", lives, exp_lives);
        if (exp_lives == 0) begin
            check_eq("over_flag", gameOver, 1);
            check_eq("over_show", showTarget, 0);
        end else begin
            check_eq("next_show", showTarget, 1);
        end
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_score = 0;
        exp_lives = MAXL;
        check_eq("start_show", showTarget, 1);
        check_eq("start_score", score, 0);
        check_eq("start_lives", lives, MAXL);
        check_eq("start_over", gameOver, 0);
    endtask

    initial begin
        exp_score = 0;
        exp_lives = MAXL;
        exp_t     = '0;
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_reset_outs("idle");

        // Game 1: drive score to saturation, then lose all lives
        start_game();
        for (int r = 0; r < 258; r++) begin
            play_round(1'b1, 1'($urandom % 2), $urandom_range(0, 3), 1'b0, 1'b0);
        end
        check_eq("score_sat", score, 255);
        play_round(1'b0, 1'b1, 0, 1'b1, 1'b0);
        play_round(1'b0, 1'b0, 2, 1'b0, 1'b0);
        play_round(1'b0, 1'b0, $urandom_range(0, 3), 1'($urandom % 2), 1'b0);

        // OVER ignores entries and holds the score
        entry      = 16'($urandom);
        entryReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("over_hold", gameOver, 1);
            check_eq("over_res", result, 0);
            check_eq("over_score", score, 255);
            check_eq("over_lives", lives, 0);
        end
        entryReady = 1'b0;

        // Game 2: random mix of passes and fails
        start_game();
        for (int r = 0; r < 30 && exp_lives > 0; r++) begin
            play_round((r < 20) && ($urandom % 3 != 0), 1'($urandom % 2),
                       $urandom_range(0, 3), 1'($urandom % 2), 1'b0);
        end
        check_eq("game2_over", gameOver, 1);

        // Game 3: reset in the middle of RESULT
        start_game();
        play_round(1'b1, 1'b0, 1, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        check_reset_outs("post_rst");
        start_game();
        check_eq("seed_target", target, 16'h0241);
        play_round(1'($urandom % 2), 1'b1, $urandom_range(0, 3), 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/round_checker.md
# round_checker

Per-round game controller for the memorization game, directly downstream of the keypad decoder. It generates a 4-digit BCD target, shows it for a fixed time, and clears the decoder. It then waits for the decoder's 4-digit entry, compares the entry with the target, and updates score and lives. Its outputs drive the display stage.

## Interface
- SHOW_CYCLES, 200_000_000: cycles the target stays visible (2 s at 100 MHz).
- RESULT_CYCLES, 100_000_000: cycles the pass/fail result is held.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.
- MAX_LIVES, 3: lives at game start; legal range 1..3.

- masterClk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high; clock masterClk.
- start  in  1  synchronous pulse; begins a game from IDLE or OVER.
- entry  in  16  four BCD digits from the decoder; newest digit in [3:0], oldest in [15:12].
- entryReady  in  1  decoder level flag; high means all four digits are captured.
- entryClear  out  1  one-cycle pulse that clears the decoder (wired to its rst).
- target  out  16  current target; four BCD digits, same ordering as entry.
- showTarget  out  1  high while the target is to be displayed.
- result  out  2  result code: 00 none, 01 pass, 10 fail.
- score  out  8  rounds passed, binary, saturating.
- lives  out  2  remaining lives.
- gameOver  out  1  high in OVER.

## Operation
- **LFSR.** A 16-bit Galois LFSR (taps 16,14,13,11) advances every cycle from reset.
- **Digit generation.** Each LFSR nibble n maps to a digit as follows: if n ≥ 10, digit = n − 10; otherwise digit = n.
- **Target latch.** The mapped value is latched into target when a round begins.
- **State machine.** States: IDLE, SHOW, ENTRY, RESULT, OVER.
- **IDLE**
  - Outputs: showTarget=0, result=00, score=0, lives=MAX_LIVES.
  - On start: latch target, clear the show counter, go to SHOW.
- **SHOW**
  - Outputs: showTarget=1.
  - entryReady is ignored.
  - When the counter reaches SHOW_CYCLES−1: go to ENTRY and assert entryClear for exactly that transition cycle.
- **ENTRY**
  - Outputs: showTarget=0.
  - entryReady is sampled only when entryClear=0.
  - When entryReady=1 and entry==target: result=01, score=score+1 (saturates at 255).
  - When entryReady=1 and entry!=target: result=10, lives=lives−1.
  - In both cases, go to RESULT.
- **RESULT**
  - Hold result for RESULT_CYCLES.
  - At the end: result=00.
    - If lives==0, go to OVER.
    - Otherwise latch a new target and go to SHOW.
- **OVER**
  - Outputs: gameOver=1; score is held.
  - On start: score=0, lives=MAX_LIVES, gameOver=0, latch target, go to SHOW.
- **start handling.** start is ignored in SHOW, ENTRY and RESULT.
- **Entry digits.** Any entry digit equal to 4'hF (unfilled) produces a mismatch, which counts as a fail.

## Timing
- **Reset values.** All outputs reset to 0, except lives=MAX_LIVES. State=IDLE; LFSR=LFSR_SEED.
- **start latency.** start high at edge N: showTarget=1 and the new target are valid after edge N.
- **SHOW duration.** showTarget is high for exactly SHOW_CYCLES cycles.
- **entryClear.** It is high in the same cycle showTarget falls. Any entryReady in that cycle is ignored, which covers the decoder flag being stale.
- **Compare latency.** entryReady sampled at edge M: result, score and lives are updated after edge M.
- **RESULT duration.** result is nonzero for exactly RESULT_CYCLES cycles.
- **Reset mid-operation.** Outputs return to reset values immediately (asynchronous). The round in progress is discarded.
- **Saturation and underflow.** Score at 255 stays at 255 on a pass. Lives never decrements below 0, because OVER is entered when lives reaches 0.

## Structure
- **game_pkg** holds:
  - the state enum;
  - result codes RES_NONE/RES_PASS/RES_FAIL;
  - DIGIT_W=4 and the BLANK_DIGIT=4'hF constant;
  - the LFSR tap mask.
- **lfsr16** is a sub-module: free-running, parameter SEED, output 16 bits, reset on rst.
- **round_checker** holds the FSM, the counters and the comparator.

## Test plan
All scenarios use SHOW_CYCLES=4, RESULT_CYCLES=3, MAX_LIVES=3.
- Reset then idle 10 cycles → showTarget=0, result=00, score=0, lives=3, gameOver=0, entryClear=0.
- start pulse → showTarget high for exactly 4 cycles; then a single-cycle entryClear; every nibble of target is ≤ 9.
- In ENTRY, drive entry=target with entryReady=1 → next cycle result=01 for 3 cycles and score=1; then SHOW restarts with a new target.
- Drive entry=16'h1234 when target≠16'h1234, three rounds in a row → lives goes 2, 1, 0; gameOver=1; further entryReady is ignored; start restores lives=3 and score=0.
- Hold entryReady=1 throughout SHOW and during the entryClear cycle → no compare happens until the first cycle after entryClear.
- Assert rst mid-RESULT → all outputs are at reset values in the same cycle; the next start begins from target = mapped LFSR_SEED sequence.
